// File: rtl/fetch_stage.sv
// Instruction fetch: PC, single-outstanding imem requests, 2-entry {pc, word} queue; response in N -> inst_valid in N+1.
// Requests stall while the queue is full; stall holds the head; redirect flushes. FETCH_PERF_EN adds perf_fetched/perf_dropped.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        stall,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_dropped
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } state_t;

   localparam logic [31:0] NOP = 32'h0000_0013;

   state_t      state, state_nx;
   logic [31:0] pc;
   logic [31:0] req_pc;
   logic [31:0] q_pc  [2];
   logic [31:0] q_dat [2];
   logic        rd_ptr;
   logic        wr_ptr;
   logic [1:0]  count;
   logic        hs;
   logic        push;
   logic        pop;
   logic        discard;
   logic        unused_pc_bits;

   assign unused_pc_bits = ^redirect_pc[1:0];

   always_comb begin
      state_nx       = state;
      imem_req_valid = 1'b0;
      hs             = 1'b0;
      push           = 1'b0;
      discard        = 1'b0;
      case (state)
         S_REQ: begin
            imem_req_valid = (count != 2'd2) && !reset;
            hs             = imem_req_valid && imem_req_ready;
            if (hs)
               state_nx = redirect ? S_DROP : S_WAIT;
         end
         S_WAIT: begin
            if (imem_rsp_valid) begin
               state_nx = S_REQ;
               push     = !redirect;
               discard  = redirect;
            end else if (redirect) begin
               state_nx = S_DROP;
            end
         end
         S_DROP: begin
            if (imem_rsp_valid) begin
               state_nx = S_REQ;
               discard  = 1'b1;
            end
         end
         default: state_nx = S_REQ;
      endcase
   end

   assign imem_req_addr = pc;
   assign inst_valid    = (count != 2'd0);
   // A redirect flushes the queue, so the head is not consumed that cycle.
   assign pop           = inst_valid && !stall && !redirect;
   assign inst          = inst_valid ? q_dat[rd_ptr] : NOP;
   assign inst_pc       = inst_valid ? q_pc[rd_ptr]  : 32'h0000_0000;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_REQ;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else begin
         state <= state_nx;
         if (hs)
            req_pc <= pc;
         if (redirect)
            pc <= {redirect_pc[31:2], 2'b00};
         else if (hs)
            pc <= pc + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            q_pc[i]  <= 32'h0000_0000;
            q_dat[i] <= 32'h0000_0000;
         end
      end else if (redirect) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            q_pc[wr_ptr]  <= req_pc;
            q_dat[wr_ptr] <= imem_rsp_data;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop)
            rd_ptr <= ~rd_ptr;
         if (push && !pop)
            count <= count + 2'd1;
         else if (pop && !push)
            count <= count - 2'd1;
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= 32'h0000_0000;
         perf_dropped <= 32'h0000_0000;
      end else begin
         if (push)
            perf_fetched <= perf_fetched + 32'd1;
         // Discarded response plus every queued entry lost to a flush.
         perf_dropped <= perf_dropped + {31'd0, discard} + (redirect ? {30'd0, count} : 32'd0);
      end
   end
`endif

endmodule
